mic_regbank: RTL and testbench
==============================

// Module: mic_regbank
// PURPOSE
//  Microarchitecture register bank that sources the ALU operands and sinks its result.
//  Holds MAR, MDR, PC, MBR, SP, LV, CPP, TOS, OPC and H.
//  H drives the A bus; a 4-bit selector picks the B-bus source.
//  The C bus (ALU/shifter result) is written back on the clock edge under a 9-bit enable mask.
//  Also accepts memory-returned data into MDR/MBR and presents MAR/MDR/PC to the memory interface.
// PARAMETERS
//  NBITS      32        datapath width (from definitions.svh)
//  SP_RESET   'h0000_8000  reset value of SP
//  LV_RESET   'h0000_C000  reset value of LV
//  CPP_RESET  'h0000_4000  reset value of CPP
// PORTS
//  clk          in   1      single clock, all state updates on posedge
//  reset        in   1      asynchronous, active-high; clears/initialises all registers
//  c_bus        in   NBITS  writeback data
//  c_en         in   9      write mask: [0]MAR [1]MDR [2]PC [3]SP [4]LV [5]CPP [6]TOS [7]OPC [8]H
//  b_sel        in   4      B-bus source select
//  mdr_ld       in   1      memory read data valid, load MDR
//  mdr_din      in   NBITS  memory word read data
//  mbr_ld       in   1      memory fetch data valid, load MBR
//  mbr_din      in   8      memory byte fetch data
//  a_bus        out  NBITS  = H
//  b_bus        out  NBITS  selected B source (combinational from registers)
//  mar_out      out  NBITS  word address to memory
//  mdr_out      out  NBITS  write data to memory
//  pc_out       out  NBITS  byte fetch address to memory
// BEHAVIOUR
//  Register reset values:
//   - SP=SP_RESET, LV=LV_RESET, CPP=CPP_RESET; all other registers 0.
//   - All outputs therefore reflect reset values while reset is high; b_bus=MDR=0.
//  Write rules:
//   - Register X loads c_bus at posedge when its c_en bit is 1; otherwise holds.
//   - Multiple c_en bits may be set together; all selected registers load the same value.
//  b_sel decode (combinational, zero added latency):
//   - 0 MDR, 1 PC, 2 MBR sign-extended {{NBITS-8{MBR[7]}},MBR}, 3 MBR zero-extended,
//   - 4 SP, 5 LV, 6 CPP, 7 TOS, 8 OPC, 9..15 -> all zeros.
//   - H is not selectable on B.
//  Read timing:
//   - Reads return pre-edge values; a write at edge k is visible on a_bus/b_bus after edge k.
//   - No write-through bypass; this avoids a combinational loop through the ALU.
//  MDR/MBR loading and conflicts:
//   - mdr_ld=1 loads mdr_din into MDR.
//   - If mdr_ld and c_en[1] are both set in one cycle, c_bus wins and memory data is dropped.
//   - mbr_ld=1 loads mbr_din into MBR; MBR is not C-bus writable.
//  Reset mid-operation: asynchronous reset overrides any pending write in that cycle; reset wins over all loads.
// CONFIGURATION
//  REGBANK_WORD_ADDR_EN:
//   - Defined: mar_out = {MAR[NBITS-3:0],2'b00} (word index to byte address).
//   - Undefined: mar_out = MAR unmodified.
//   - pc_out is always PC unmodified.
// TESTING
//  1. Assert reset -> SP=0x8000, LV=0xC000, CPP=0x4000, others 0; b_sel=4 gives b_bus=0x8000.
//  2. c_bus=0x1234, c_en=9'h140 (TOS,H) -> next cycle a_bus=0x1234; b_sel=7 gives 0x1234; MAR unchanged.
//  3. mbr_ld=1, mbr_din=0x9C -> b_sel=2 gives 0xFFFFFF9C, b_sel=3 gives 0x0000009C.
//  4. Same cycle mdr_ld=1 (mdr_din=0xAAAA5555) and c_en[1]=1 (c_bus=0x11) -> MDR=0x11.
//  5. MAR written 0x00000010 -> mar_out=0x40 with REGBANK_WORD_ADDR_EN, 0x10 without.
//  6. Reset pulsed between edges while c_en=9'h1FF -> all registers at reset values; no write lands; b_sel=12 -> b_bus=0.

Source files
------------

// File: rtl/mic_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : mic_regbank
//  Description : Microarchitecture register bank. H feeds the A bus, a 4-bit
//                selector picks the B bus, the C bus is written back under a
//                9-bit enable mask. Memory data loads MDR/MBR.
//                Optional macro REGBANK_WORD_ADDR_EN turns mar_out into a
//                byte address (MAR shifted left by 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module mic_regbank #(
  parameter int               NBITS     = 32,
  parameter logic [NBITS-1:0] SP_RESET  = 'h0000_8000,
  parameter logic [NBITS-1:0] LV_RESET  = 'h0000_C000,
  parameter logic [NBITS-1:0] CPP_RESET = 'h0000_4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] c_bus,
  input  logic [8:0]       c_en,
  input  logic [3:0]       b_sel,
  input  logic             mdr_ld,
  input  logic [NBITS-1:0] mdr_din,
  input  logic             mbr_ld,
  input  logic [7:0]       mbr_din,
  output logic [NBITS-1:0] a_bus,
  output logic [NBITS-1:0] b_bus,
  output logic [NBITS-1:0] mar_out,
  output logic [NBITS-1:0] mdr_out,
  output logic [NBITS-1:0] pc_out
);

  localparam int C_EN_MAR = 0;
  localparam int C_EN_MDR = 1;
  localparam int C_EN_PC  = 2;
  localparam int C_EN_SP  = 3;
  localparam int C_EN_LV  = 4;
  localparam int C_EN_CPP = 5;
  localparam int C_EN_TOS = 6;
  localparam int C_EN_OPC = 7;
  localparam int C_EN_H   = 8;

  logic [NBITS-1:0] r_mar, r_mdr, r_pc, r_sp, r_lv, r_cpp, r_tos, r_opc, r_h;
  logic [7:0]       r_mbr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mar <= '0;
      r_mdr <= '0;
      r_pc  <= '0;
      r_mbr <= '0;
      r_sp  <= SP_RESET;
      r_lv  <= LV_RESET;
      r_cpp <= CPP_RESET;
      r_tos <= '0;
      r_opc <= '0;
      r_h   <= '0;
    end else begin
      if (c_en[C_EN_MAR]) r_mar <= c_bus;
      // C-bus writeback has priority; simultaneous memory data is dropped
      if (c_en[C_EN_MDR])  r_mdr <= c_bus;
      else if (mdr_ld)     r_mdr <= mdr_din;
      if (c_en[C_EN_PC])  r_pc  <= c_bus;
      if (c_en[C_EN_SP])  r_sp  <= c_bus;
      if (c_en[C_EN_LV])  r_lv  <= c_bus;
      if (c_en[C_EN_CPP]) r_cpp <= c_bus;
      if (c_en[C_EN_TOS]) r_tos <= c_bus;
      if (c_en[C_EN_OPC]) r_opc <= c_bus;
      if (c_en[C_EN_H])   r_h   <= c_bus;
      if (mbr_ld)         r_mbr <= mbr_din;
    end
  end

  // B bus reads registered values only, so no path from c_bus back to the ALU
  always_comb begin
    b_bus = '0;
    case (b_sel)
      4'd0:    b_bus = r_mdr;
      4'd1:    b_bus = r_pc;
      4'd2:    b_bus = {{(NBITS-8){r_mbr[7]}}, r_mbr};
      4'd3:    b_bus = {{(NBITS-8){1'b0}}, r_mbr};
      4'd4:    b_bus = r_sp;
      4'd5:    b_bus = r_lv;
      4'd6:    b_bus = r_cpp;
      4'd7:    b_bus = r_tos;
      4'd8:    b_bus = r_opc;
      default: b_bus = '0;
    endcase
  end

  assign a_bus   = r_h;
  assign mdr_out = r_mdr;
  assign pc_out  = r_pc;

`ifdef REGBANK_WORD_ADDR_EN
  assign mar_out = {r_mar[NBITS-3:0], 2'b00};
`else
  assign mar_out = r_mar;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mic_regbank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mic_regbank
//  Description : Randomised and directed check of mic_regbank against a
//                register-array model of the bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mic_regbank;

  localparam int NBITS = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NBITS-1:0] c_bus;
  logic [8:0]       c_en;
  logic [3:0]       b_sel;
  logic             mdr_ld;
  logic [NBITS-1:0] mdr_din;
  logic             mbr_ld;
  logic [7:0]       mbr_din;
  logic [NBITS-1:0] a_bus, b_bus, mar_out, mdr_out, pc_out;

  int n_cmp = 0;
  int n_err = 0;

  // model: 0 MAR 1 MDR 2 PC 3 SP 4 LV 5 CPP 6 TOS 7 OPC 8 H, plus MBR byte
  logic [31:0] m [0:8];
  logic [7:0]  m_mbr;

  mic_regbank dut (
    .clk     (clk),
    .reset   (reset),
    .c_bus   (c_bus),
    .c_en    (c_en),
    .b_sel   (b_sel),
    .mdr_ld  (mdr_ld),
    .mdr_din (mdr_din),
    .mbr_ld  (mbr_ld),
    .mbr_din (mbr_din),
    .a_bus   (a_bus),
    .b_bus   (b_bus),
    .mar_out (mar_out),
    .mdr_out (mdr_out),
    .pc_out  (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 9; i++) m[i] = 32'h0;
    m[3]  = 32'h0000_8000;
    m[4]  = 32'h0000_C000;
    m[5]  = 32'h0000_4000;
    m_mbr = 8'h00;
  endfunction

  function automatic void model_clock();
    for (int i = 0; i < 9; i++)
      if (c_en[i]) m[i] = c_bus;
    if (mdr_ld && !c_en[1]) m[1] = mdr_din;
    if (mbr_ld) m_mbr = mbr_din;
  endfunction

  function automatic logic [31:0] exp_b(input logic [3:0] sel);
    logic [31:0] z;
    z = {24'h0, m_mbr};
    case (sel)
      4'd0: return m[1];
      4'd1: return m[2];
      4'd2: return (z >= 32'd128) ? z + 32'hFFFF_FF00 : z;
      4'd3: return z;
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8: return m[sel - 4'd1];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_mar();
`ifdef REGBANK_WORD_ADDR_EN
    return m[0] * 32'd4;
`else
    return m[0];
`endif
  endfunction

  task automatic idle();
    c_en = 9'h0; c_bus = '0; mdr_ld = 1'b0; mdr_din = '0;
    mbr_ld = 1'b0; mbr_din = 8'h0;
  endtask

  // checks every visible output, sweeping b_sel within one half period
  task automatic check_all(input string tag);
    check({tag, "_a"},   a_bus,   m[8]);
    check({tag, "_mar"}, mar_out, exp_mar());
    check({tag, "_mdr"}, mdr_out, m[1]);
    check({tag, "_pc"},  pc_out,  m[2]);
    for (int s = 0; s < 16; s++) begin
      b_sel = 4'(s);
      #0.2;
      check($sformatf("%s_b%0d", tag, s), b_bus, exp_b(4'(s)));
    end
  endtask

  task automatic step(input logic [8:0] en, input logic [31:0] cb,
                      input logic mdl, input logic [31:0] md,
                      input logic mbl, input logic [7:0] mb);
    @(negedge clk);
    c_en = en; c_bus = cb; mdr_ld = mdl; mdr_din = md; mbr_ld = mbl; mbr_din = mb;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    idle();
    #1;
  endtask

  initial begin
    idle();
    b_sel = 4'd0;
    reset = 1'b1;
    model_reset();
    #3;
    b_sel = 4'd4;
    #1;
    check("rst_sp_async", b_bus, 32'h0000_8000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_all("t1_reset");
    b_sel = 4'd5; #0.5; check("t1_lv",  b_bus, 32'h0000_C000);
    b_sel = 4'd6; #0.5; check("t1_cpp", b_bus, 32'h0000_4000);

    // TOS and H together, MAR untouched
    step(9'h140, 32'h1234, 1'b0, '0, 1'b0, 8'h0);
    check("t2_a", a_bus, 32'h1234);
    b_sel = 4'd7; #0.5; check("t2_tos", b_bus, 32'h1234);
    check("t2_mar", mar_out, 32'h0);

    step(9'h0, '0, 1'b0, '0, 1'b1, 8'h9C);
    b_sel = 4'd2; #0.5; check("t3_sext", b_bus, 32'hFFFF_FF9C);
    b_sel = 4'd3; #0.5; check("t3_zext", b_bus, 32'h0000_009C);

    step(9'h002, 32'h11, 1'b1, 32'hAAAA_5555, 1'b0, 8'h0);
    check("t4_mdr_conflict", mdr_out, 32'h11);
    step(9'h000, '0, 1'b1, 32'hAAAA_5555, 1'b0, 8'h0);
    check("t4_mdr_load", mdr_out, 32'hAAAA_5555);

    step(9'h001, 32'h10, 1'b0, '0, 1'b0, 8'h0);
`ifdef REGBANK_WORD_ADDR_EN
    check("t5_mar", mar_out, 32'h40);
`else
    check("t5_mar", mar_out, 32'h10);
`endif
    check_all("t5");

    // randomised traffic
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      c_en    = 9'($urandom & $urandom);
      c_bus   = $urandom;
      b_sel   = 4'($urandom_range(0, 15));
      mdr_ld  = 1'($urandom_range(0, 3) == 0);
      mdr_din = $urandom;
      mbr_ld  = 1'($urandom_range(0, 3) == 0);
      mbr_din = 8'($urandom);
      #1;
      check("rnd_a",   a_bus,   m[8]);
      check("rnd_b",   b_bus,   exp_b(b_sel));
      check("rnd_mar", mar_out, exp_mar());
      check("rnd_mdr", mdr_out, m[1]);
      check("rnd_pc",  pc_out,  m[2]);
      @(posedge clk);
      model_clock();
    end
    @(negedge clk);
    idle();
    #1;
    check_all("rnd_end");

    // reset pulse between edges with every write enabled
    @(negedge clk);
    c_en = 9'h1FF; c_bus = 32'hDEAD_BEEF; mdr_ld = 1'b1; mdr_din = 32'h5A5A_5A5A;
    mbr_ld = 1'b1; mbr_din = 8'hE7;
    #1 reset = 1'b1;
    model_reset();
    #0.5;
    check("t6_a_in_reset", a_bus, 32'h0);
    check("t6_mdr_in_reset", mdr_out, 32'h0);
    #0.5 reset = 1'b0;
    idle();
    @(posedge clk);
    @(negedge clk);
    check_all("t6");
    b_sel = 4'd12; #0.5; check("t6_b12", b_bus, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
